// File: rtl/cla_addsub_pipe_if.sv
// Stream interface for cla_addsub_pipe.
//   in_valid/in_ready : operand beat handshake (a, b, cin, op)
//   out_valid/out_ready : result beat handshake (sum, cout, ovf, zero)
// The master drives operands and out_ready; the slave (the adder) drives in_ready and results.
interface cla_addsub_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor.
// The operand is cut into STAGES slices of SLICE = WIDTH/STAGES bits. Stage s resolves slice s
// with BLOCK-bit lookahead groups (group P/G, then per-bit carries inside each group) using the
// carry registered by stage s-1; stage 0 works straight from the input port.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, clears every pipeline register
//   bus_io : slave side of cla_addsub_pipe_if (operand stream in, result stream out)
// Result latency: a beat accepted on edge t is on the outputs right after edge t+STAGES-1.
module cla_addsub_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 4
) (
  input logic                 clk,
  input logic                 rst,
  cla_addsub_pipe_if.slave    bus_io
);

  localparam int unsigned SLICE = WIDTH / STAGES;
  localparam int unsigned NGRP  = SLICE / BLOCK;

  if ((STAGES == 0) || (BLOCK == 0) || ((WIDTH % (STAGES * BLOCK)) != 0)) begin : g_param_check
    $error("cla_addsub_pipe: WIDTH must be a non-zero multiple of STAGES*BLOCK");
  end

  typedef logic [SLICE-1:0] slice_t;

  // Returns {carry_in_msb ^ carry_out, carry_out, sum} for one slice.
  function automatic logic [SLICE+1:0] cla_slice(input slice_t x, input slice_t y,
                                                 input logic ci);
    slice_t          p;
    slice_t          g;
    slice_t          s;
    logic [SLICE:0]  c;
    logic [NGRP-1:0] gp;
    logic [NGRP-1:0] gg;
    logic [NGRP:0]   gc;
    p = x ^ y;
    g = x & y;
    // Level 1: group propagate / generate.
    for (int j = 0; j < NGRP; j++) begin
      gp[j] = &p[j*BLOCK +: BLOCK];
      gg[j] = 1'b0;
      for (int k = 0; k < BLOCK; k++) begin
        gg[j] = g[j*BLOCK+k] | (p[j*BLOCK+k] & gg[j]);
      end
    end
    // Level 2: carries into each group from group P/G only.
    gc[0] = ci;
    for (int j = 0; j < NGRP; j++) begin
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
    // Per-bit carries inside each group, seeded by the group carry.
    c = '0;
    for (int j = 0; j < NGRP; j++) begin
      c[j*BLOCK] = gc[j];
      for (int k = 1; k < BLOCK; k++) begin
        c[j*BLOCK+k] = g[j*BLOCK+k-1] | (p[j*BLOCK+k-1] & c[j*BLOCK+k-1]);
      end
    end
    c[SLICE] = gc[NGRP];
    s = p ^ c[SLICE-1:0];
    return {c[SLICE] ^ c[SLICE-1], c[SLICE], s};
  endfunction

  // Per-stage register contents. acc holds finished sum slices below the current stage and
  // still-raw operand A slices above it; bp holds the op-adjusted operand B'.
  logic [STAGES-1:0][WIDTH-1:0] acc_d, acc_q;
  logic [STAGES-1:0][WIDTH-1:0] bp_d, bp_q;
  logic [STAGES-1:0]            c_d, c_q;
  logic [STAGES-1:0]            z_d, z_q;
  logic [STAGES-1:0]            v_d, v_q;
  logic                         ovf_d, ovf_q;

  // Inputs seen by each stage: ports for stage 0, previous register otherwise.
  logic [STAGES-1:0][WIDTH-1:0] src_acc;
  logic [STAGES-1:0][WIDTH-1:0] src_bp;
  logic [STAGES-1:0]            src_c;
  logic [STAGES-1:0]            src_z;
  logic [STAGES-1:0]            src_v;
  logic [STAGES-1:0][SLICE+1:0] res;

  logic en;
  logic accept;

  // The whole pipe freezes only when a finished result is not being taken.
  assign en     = ~(v_q[STAGES-1] & ~bus_io.out_ready);
  assign accept = bus_io.in_valid & en;

  always_comb begin
    src_acc = '0;
    src_bp  = '0;
    src_c   = '0;
    src_z   = '0;
    src_v   = '0;
    res     = '0;
    acc_d   = '0;
    bp_d    = '0;
    c_d     = '0;
    z_d     = '0;
    v_d     = '0;
    ovf_d   = 1'b0;

    // Subtraction as a + ~b + ~cin; c0 = cin ^ op covers both cases.
    src_acc[0] = bus_io.a;
    src_bp[0]  = bus_io.op ? ~bus_io.b : bus_io.b;
    src_c[0]   = bus_io.cin ^ bus_io.op;
    src_z[0]   = 1'b1;
    src_v[0]   = accept;
    for (int s = 1; s < STAGES; s++) begin
      src_acc[s] = acc_q[s-1];
      src_bp[s]  = bp_q[s-1];
      src_c[s]   = c_q[s-1];
      src_z[s]   = z_q[s-1];
      src_v[s]   = v_q[s-1];
    end

    for (int s = 0; s < STAGES; s++) begin
      res[s] = cla_slice(src_acc[s][s*SLICE +: SLICE], src_bp[s][s*SLICE +: SLICE], src_c[s]);
      acc_d[s]                   = src_acc[s];
      acc_d[s][s*SLICE +: SLICE] = res[s][SLICE-1:0];
      bp_d[s]                    = src_bp[s];
      c_d[s]                     = res[s][SLICE];
      z_d[s]                     = src_z[s] & ~|res[s][SLICE-1:0];
      v_d[s]                     = src_v[s];
    end

    // Only the MSB slice's internal carry pair defines signed overflow.
    ovf_d = res[STAGES-1][SLICE+1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      bp_q  <= '0;
      c_q   <= '0;
      z_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      acc_q <= acc_d;
      bp_q  <= bp_d;
      c_q   <= c_d;
      z_q   <= z_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus_io.in_ready  = en;
  assign bus_io.out_valid = v_q[STAGES-1];
  assign bus_io.sum       = acc_q[STAGES-1];
  assign bus_io.cout      = c_q[STAGES-1];
  assign bus_io.ovf       = ovf_q;
  assign bus_io.zero      = z_q[STAGES-1];

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: directed cases on a 32-bit/4-stage instance plus randomized
// streams on (16,1), (32,4) and (64,2) instances, all scored against a plain-arithmetic model.
module tb_cla_addsub_pipe;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  localparam int unsigned NBEATS = 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_r;
  int   checks = 0;
  int   errors = 0;

  // Reference: {cout,sum} = a + B' + c0, signed overflow from operand/result signs.
  function automatic exp_t model(int unsigned w, logic [63:0] a, logic [63:0] b,
                                 logic cin, logic op);
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] bp;
    logic [64:0] full;
    logic        c0;
    exp_t        e;
    mask   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    am     = a & mask;
    bp     = (op ? ~b : b) & mask;
    c0     = op ? ~cin : cin;
    full   = {1'b0, am} + {1'b0, bp} + {64'd0, c0};
    e.sum  = full[63:0] & mask;
    e.cout = full[w];
    e.ovf  = (am[w-1] == bp[w-1]) && (e.sum[w-1] != am[w-1]);
    e.zero = (e.sum == 64'd0);
    return e;
  endfunction

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(7))
      0: v = '0;
      1: v = '1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic chk(string nm, exp_t act, exp_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got sum=%h cout=%b ovf=%b zero=%b, want sum=%h cout=%b ovf=%b zero=%b",
               nm, act.sum, act.cout, act.ovf, act.zero, req.sum, req.cout, req.ovf, req.zero);
    end
  endtask

  task automatic chk1(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  task automatic fail_now(string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // ---------------- directed instance (32 bits, 4 stages) ----------------
  cla_addsub_pipe_if #(.WIDTH(32)) m_if ();
  cla_addsub_pipe #(.WIDTH(32), .BLOCK(4), .STAGES(4)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (m_if)
  );

  exp_t mq[$];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_if.out_valid && m_if.out_ready) begin
        if (mq.size() == 0) begin
          fail_now($sformatf("main_unexpected_output sum=%h", m_if.sum));
        end else begin
          e = mq.pop_front();
          chk("main_result", {32'd0, m_if.sum, m_if.cout, m_if.ovf, m_if.zero}, e);
        end
      end
    end
  end

  function automatic exp_t mk(logic [63:0] s, logic c, logic o, logic z);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = o;
    e.zero = z;
    return e;
  endfunction

  // Drive one beat from posedge+1 and hold it until accepted.
  task automatic issue(logic [31:0] a, logic [31:0] b, logic cin, logic op, bit push,
                       exp_t e);
    int n;
    @(posedge clk);
    #1;
    m_if.in_valid = 1'b1;
    m_if.a        = a;
    m_if.b        = b;
    m_if.cin      = cin;
    m_if.op       = op;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_if.in_ready && n < 50);
    if (m_if.in_ready) begin
      if (push) mq.push_back(e);
    end else begin
      fail_now("issue_timeout");
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    m_if.in_valid = 1'b0;
  endtask

  task automatic drain(string nm);
    int n;
    n = 0;
    while (mq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mq.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d results never appeared, want 0", nm, mq.size());
    end
  endtask

  task automatic check_reset_outputs(string pfx);
    chk1({pfx, "_out_valid"}, 64'(m_if.out_valid), 64'd0);
    chk1({pfx, "_sum"},       64'(m_if.sum),       64'd0);
    chk1({pfx, "_cout"},      64'(m_if.cout),      64'd0);
    chk1({pfx, "_ovf"},       64'(m_if.ovf),       64'd0);
    chk1({pfx, "_zero"},      64'(m_if.zero),      64'd0);
    chk1({pfx, "_in_ready"},  64'(m_if.in_ready),  64'd1);
  endtask

  // ---------------- randomized instances ----------------
  for (genvar k = 0; k < 3; k++) begin : g_rnd
    localparam int unsigned W = (k == 0) ? 16 : (k == 1) ? 32 : 64;
    localparam int unsigned S = (k == 0) ? 1 : (k == 1) ? 4 : 2;

    cla_addsub_pipe_if #(.WIDTH(W)) r_if ();
    cla_addsub_pipe #(.WIDTH(W), .BLOCK(4), .STAGES(S)) u_dut (
      .clk    (clk),
      .rst    (rst_r),
      .bus_io (r_if)
    );

    exp_t q[$];
    bit   done = 1'b0;

    initial begin
      int          acc_n;
      int          cyc;
      int          n;
      logic [63:0] a;
      logic [63:0] b;
      logic        ci;
      logic        o;
      r_if.in_valid  = 1'b0;
      r_if.a         = '0;
      r_if.b         = '0;
      r_if.cin       = 1'b0;
      r_if.op        = 1'b0;
      r_if.out_ready = 1'b0;
      do @(negedge clk); while (rst_r);
      acc_n = 0;
      cyc   = 0;
      while (acc_n < NBEATS && cyc < 60000) begin
        @(posedge clk);
        #1;
        a  = rnd64();
        b  = rnd64();
        ci = 1'($urandom_range(1));
        o  = 1'($urandom_range(1));
        r_if.in_valid  = ($urandom_range(3) != 0);
        r_if.a         = a[W-1:0];
        r_if.b         = b[W-1:0];
        r_if.cin       = ci;
        r_if.op        = o;
        r_if.out_ready = ($urandom_range(3) != 0);
        @(negedge clk);
        cyc++;
        if (r_if.in_valid && r_if.in_ready) begin
          q.push_back(model(W, a, b, ci, o));
          acc_n++;
        end
      end
      if (acc_n < NBEATS) fail_now($sformatf("rnd_w%0d_s%0d_stuck accepted=%0d", W, S, acc_n));
      @(posedge clk);
      #1;
      r_if.in_valid  = 1'b0;
      r_if.out_ready = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL rnd_w%0d_s%0d_drain: %0d results missing, want 0", W, S, q.size());
      end
      done = 1'b1;
    end

    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        if (!rst_r && r_if.out_valid && r_if.out_ready) begin
          if (q.size() == 0) begin
            fail_now($sformatf("rnd_w%0d_s%0d_unexpected_output", W, S));
          end else begin
            e = q.pop_front();
            chk($sformatf("rnd_w%0d_s%0d", W, S),
                {64'(r_if.sum), r_if.cout, r_if.ovf, r_if.zero}, e);
          end
        end
      end
    end
  end

  initial begin
    rst_r = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_r = 1'b0;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int   n;
    exp_t e;
    rst            = 1'b1;
    m_if.in_valid  = 1'b0;
    m_if.a         = '0;
    m_if.b         = '0;
    m_if.cin       = 1'b0;
    m_if.op        = 1'b0;
    m_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // 1) carry across the 16-bit boundary, with latency check
    issue(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, mk(64'h1_0000, 1'b0, 1'b0, 1'b0));
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1($sformatf("latency_valid_%0d", i), 64'(m_if.out_valid), (i == 3) ? 64'd1 : 64'd0);
    end
    drain("t1_drain");

    // 2) carry ripples through every slice register
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, mk(64'h0, 1'b1, 1'b0, 1'b1));
    idle();
    drain("t2_drain");

    // 3) subtraction with overflow, then with borrow
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, mk(64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    issue(32'd5, 32'd7, 1'b0, 1'b1, 1'b1, mk(64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    idle();
    drain("t3_drain");

    // 4) back-to-back with a 3-cycle output stall when beat 4 is offered
    for (int i = 0; i < 4; i++) begin
      issue(32'(i), 32'(i) << 8, 1'b0, 1'(i % 2), 1'b1, model(32, 64'(i), 64'(i) << 8, 1'b0,
            1'(i % 2)));
    end
    @(posedge clk);
    #1;
    m_if.in_valid  = 1'b1;
    m_if.a         = 32'd4;
    m_if.b         = 32'd4 << 8;
    m_if.cin       = 1'b0;
    m_if.op        = 1'b0;
    m_if.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c != 0) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      chk1($sformatf("stall_in_ready_%0d", c), 64'(m_if.in_ready), 64'd0);
      chk1($sformatf("stall_out_valid_%0d", c), 64'(m_if.out_valid), 64'd1);
      if (mq.size() != 0) begin
        chk($sformatf("stall_hold_%0d", c), {32'd0, m_if.sum, m_if.cout, m_if.ovf, m_if.zero},
            mq[0]);
      end else begin
        fail_now("stall_queue_empty");
      end
    end
    @(posedge clk);
    #1;
    m_if.out_ready = 1'b1;
    @(negedge clk);
    chk1("unstall_in_ready", 64'(m_if.in_ready), 64'd1);
    if (m_if.in_ready) mq.push_back(model(32, 64'd4, 64'd4 << 8, 1'b0, 1'b0));
    for (int i = 5; i < 8; i++) begin
      issue(32'(i), 32'(i) << 8, 1'b0, 1'(i % 2), 1'b1, model(32, 64'(i), 64'(i) << 8, 1'b0,
            1'(i % 2)));
    end
    idle();
    drain("t4_drain");

    // 5) reset with three beats in flight discards them
    e = mk(64'h0, 1'b0, 1'b0, 1'b0);
    issue(32'h11, 32'h22, 1'b0, 1'b0, 1'b0, e);
    issue(32'h33, 32'h44, 1'b0, 1'b0, 1'b0, e);
    issue(32'h55, 32'h66, 1'b0, 1'b0, 1'b0, e);
    @(posedge clk);
    #1;
    rst           = 1'b1;
    m_if.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    issue(32'h1, 32'h2, 1'b0, 1'b0, 1'b1, mk(64'h3, 1'b0, 1'b0, 1'b0));
    idle();
    drain("t5_drain");

    // 6) wait for the randomized streams
    n = 0;
    while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done) && n < 80000) begin
      @(posedge clk);
      n++;
    end
    if (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done)) fail_now("random_phase_timeout");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
